// File: rtl/tqv_step_responder.sv
// Stepping counter peripheral on the TinyQV bus: CTRL/VALUE/LIMIT/STATUS/ID registers, reads complete after WAIT_CYCLES+1.
// Optional wrap interrupt built only when TQV_STEP_IRQ_EN is defined; otherwise user_interrupt is tied low.
module tqv_step_responder #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = 32'h5354_5031
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt,
  output logic [7:0]  uo_out
);

  typedef enum logic [1:0] {IDLE, WAIT, READY, DONE} state_t;

  localparam logic [5:0] A_CTRL   = 6'h00;
  localparam logic [5:0] A_VALUE  = 6'h04;
  localparam logic [5:0] A_LIMIT  = 6'h08;
  localparam logic [5:0] A_STATUS = 6'h0C;
  localparam logic [5:0] A_ID     = 6'h10;
  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

  state_t      state;
  logic [2:0]  wait_cnt;
  logic        ctrl_en;
  logic [7:0]  ctrl_step;
  logic [31:0] value;
  logic [31:0] limit;
  logic        wrap;
  logic        irq_bit;
  logic [31:0] wmask;
  logic [31:0] rd_data;
  logic [32:0] next_sum;
  logic        rd_req, wr_en, value_wr, wrap_evt, status_clr;

  assign rd_req = (data_read_n != 2'b11);
  // A read in the same cycle wins over any write.
  assign wr_en  = (data_write_n != 2'b11) && !rd_req;

  always_comb begin
    wmask = 32'h0;
    case (data_write_n)
      2'b00:   wmask = 32'h0000_00FF;
      2'b01:   wmask = 32'h0000_FFFF;
      2'b10:   wmask = 32'hFFFF_FFFF;
      default: wmask = 32'h0;
    endcase
  end

`ifdef TQV_STEP_IRQ_EN
  logic ctrl_irq_en;
  assign irq_bit = ctrl_irq_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_irq_en    <= 1'b0;
      user_interrupt <= 1'b0;
    end else begin
      if (wr_en && address == A_CTRL && wmask[1])
        ctrl_irq_en <= data_in[1];
      user_interrupt <= wrap & ctrl_irq_en;
    end
  end
`else
  assign irq_bit        = 1'b0;
  assign user_interrupt = 1'b0;
`endif

  assign next_sum   = {1'b0, value} + {25'b0, ctrl_step};
  assign value_wr   = wr_en && (address == A_VALUE);
  assign wrap_evt   = ctrl_en && !value_wr && (next_sum > {1'b0, limit});
  assign status_clr = wr_en && (address == A_STATUS) && wmask[0] && data_in[0];
  assign uo_out     = value[7:0];

  always_comb begin
    rd_data = 32'h0;
    case (address)
      A_CTRL:   rd_data = {16'h0, ctrl_step, 6'h0, irq_bit, ctrl_en};
      A_VALUE:  rd_data = value;
      A_LIMIT:  rd_data = limit;
      A_STATUS: rd_data = {31'h0, wrap};
      A_ID:     rd_data = ID_VALUE;
      default:  rd_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_en   <= 1'b0;
      ctrl_step <= 8'h0;
      value     <= 32'h0;
      limit     <= 32'hFFFF_FFFF;
      wrap      <= 1'b0;
    end else begin
      if (wr_en && address == A_CTRL) begin
        if (wmask[0]) ctrl_en <= data_in[0];
        ctrl_step <= (ctrl_step & ~wmask[15:8]) | (data_in[15:8] & wmask[15:8]);
      end
      if (wr_en && address == A_LIMIT)
        limit <= (limit & ~wmask) | (data_in & wmask);
      // A bus write to VALUE replaces the step for that cycle.
      if (value_wr)
        value <= (value & ~wmask) | (data_in & wmask);
      else if (wrap_evt)
        value <= 32'h0;
      else if (ctrl_en)
        value <= next_sum[31:0];
      wrap <= (wrap & ~status_clr) | wrap_evt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= 3'd0;
      data_out   <= 32'h0;
      data_ready <= 1'b0;
    end else begin
      data_ready <= 1'b0;
      case (state)
        IDLE: if (rd_req) begin
          data_out <= rd_data;
          wait_cnt <= WAIT_INIT;
          if (WAIT_INIT == 3'd0) begin
            state      <= READY;
            data_ready <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
          if (wait_cnt <= 3'd1) begin
            state      <= READY;
            data_ready <= 1'b1;
          end
        end
        READY: state <= DONE;
        DONE:  if (!rd_req) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
